// File: rtl/rx_ctrl_pkg.sv
// Shared state encoding, frame length and ALU command codes for the receive framer.
// Defining RX_CHECKSUM_EN adds a trailing XOR check byte (six-byte frames).
package rx_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A_HI,
        B_LO,
        B_HI,
        CMD,
        CHK
    } rx_state_t;

`ifdef RX_CHECKSUM_EN
    localparam int unsigned FRAME_BYTES = 6;
`else
    localparam int unsigned FRAME_BYTES = 5;
`endif

    localparam logic [7:0] CMD_ADD = 8'h00;
    localparam logic [7:0] CMD_SUB = 8'h01;
    localparam logic [7:0] CMD_AND = 8'h02;
    localparam logic [7:0] CMD_OR  = 8'h03;

endpackage

// File: rtl/rx_timeout_timer.sv
// Inter-byte idle counter: expire fires on the last allowed idle clock unless cleared.
// TIMEOUT_CYCLES = 0 removes the counter and ties expire low.
module rx_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk, reset, clear, enable};
            assign expire = 1'b0;
        end else begin : g_on
            logic [CNT_W-1:0] count;

            assign expire = enable && !clear && (count == CNT_W'(TIMEOUT_CYCLES - 1));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    count <= '0;
                end else if (clear || !enable || expire) begin
                    count <= '0;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/rx_control.sv
// Receive framer: assembles A(16) B(16) CMD(8) from UART bytes, low byte first.
// Optional RX_CHECKSUM_EN appends an XOR check byte validated before the frame is released.
module rx_control
    import rx_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic [7:0]  op_cmd,
    output logic        frame_valid,
    output logic        frame_error,
    output logic        busy
);

    rx_state_t   state;
    logic [15:0] sh_a;
    logic [15:0] sh_b;
    logic        expire;
`ifdef RX_CHECKSUM_EN
    logic [7:0]  sh_cmd;
    logic [7:0]  chk_acc;
`endif

    rx_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (rx_ready),
        .enable(state != IDLE),
        .expire(expire)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sh_a        <= '0;
            sh_b        <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_cmd      <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
`ifdef RX_CHECKSUM_EN
            sh_cmd      <= '0;
            chk_acc     <= '0;
`endif
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            // A byte always takes priority over a coincident timeout expiry.
            if (rx_ready) begin
`ifdef RX_CHECKSUM_EN
                chk_acc <= (state == IDLE) ? rx_data : (chk_acc ^ rx_data);
`endif
                case (state)
                    IDLE: begin
                        sh_a[7:0] <= rx_data;
                        state     <= A_HI;
                    end
                    A_HI: begin
                        sh_a[15:8] <= rx_data;
                        state      <= B_LO;
                    end
                    B_LO: begin
                        sh_b[7:0] <= rx_data;
                        state     <= B_HI;
                    end
                    B_HI: begin
                        sh_b[15:8] <= rx_data;
                        state      <= CMD;
                    end
                    CMD: begin
`ifdef RX_CHECKSUM_EN
                        sh_cmd <= rx_data;
                        state  <= CHK;
`else
                        op_a        <= sh_a;
                        op_b        <= sh_b;
                        op_cmd      <= rx_data;
                        frame_valid <= 1'b1;
                        state       <= IDLE;
`endif
                    end
`ifdef RX_CHECKSUM_EN
                    CHK: begin
                        if (rx_data == chk_acc) begin
                            op_a        <= sh_a;
                            op_b        <= sh_b;
                            op_cmd      <= sh_cmd;
                            frame_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                        state <= IDLE;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end else if (expire) begin
                state       <= IDLE;
                frame_error <= 1'b1;
            end
        end
    end

endmodule
